// File: rtl/seq_pkg.sv
// seq_pkg: FSM states and default widths shared by the sequence generator and detector
package seq_pkg;
    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 3;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
endpackage

// File: rtl/seq_shifter.sv
// seq_shifter: captured pattern plus working shift register, exposing the bit at position len-1
module seq_shifter import seq_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_reload,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_data,
    input  logic [LEN_W-1:0] i_len,
    output logic [LEN_W-1:0] o_len,
    output logic             o_load_msb,
    output logic             o_head_msb,
    output logic             o_next_msb
);
    logic [PAT_W-1:0] r_cap;
    logic [PAT_W-1:0] r_sh;
    logic [LEN_W-1:0] r_len;

    function automatic logic msb_at(input logic [PAT_W-1:0] v, input logic [LEN_W-1:0] l);
        logic [PAT_W-1:0] t;
        t = v >> (l - 1'b1);
        return (l != '0) & t[0];
    endfunction

    // capture a new pattern, restart a repetition from the capture, or advance one bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap <= '0;
            r_sh  <= '0;
            r_len <= '0;
        end else if (i_load) begin
            r_cap <= i_data;
            r_sh  <= i_data;
            r_len <= i_len;
        end else if (i_reload) begin
            r_sh <= r_cap;
        end else if (i_shift) begin
            r_sh <= r_sh << 1;
        end
    end

    assign o_len      = r_len;
    assign o_load_msb = msb_at(i_data, i_len);
    assign o_head_msb = msb_at(r_cap, r_len);
    assign o_next_msb = msb_at(r_sh << 1, r_len);
endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter, MSB-first with repeat count and inter-repeat gap
module seq_gen import seq_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             seq_out,
    output logic             seq_vld,
    output logic             busy,
    output logic             done
);
    state_t           r_state, w_state;
    logic [LEN_W-1:0] r_bit, w_bit, w_len, w_cur_len;
    logic [CNT_W-1:0] r_rep, w_rep, w_reps;
    logic [GAP_W-1:0] r_gap, w_gap, r_gap_cfg, w_gap_cfg;
    logic             r_out, w_out, r_vld, w_vld, r_done, w_done;
    logic             w_load, w_reload, w_shift;
    logic             w_load_msb, w_head_msb, w_next_msb;

    assign w_len  = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign w_reps = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;

    seq_shifter #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_reload   (w_reload),
        .i_shift    (w_shift),
        .i_data     (pat_data),
        .i_len      (w_len),
        .o_len      (w_cur_len),
        .o_load_msb (w_load_msb),
        .o_head_msb (w_head_msb),
        .o_next_msb (w_next_msb)
    );

    // state, counters and registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            r_gap_cfg <= '0;
            r_out     <= 1'b0;
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit     <= w_bit;
            r_rep     <= w_rep;
            r_gap     <= w_gap;
            r_gap_cfg <= w_gap_cfg;
            r_out     <= w_out;
            r_vld     <= w_vld;
            r_done    <= w_done;
        end
    end

    // next state: outputs default to idle line, each branch drives the bit it will present
    always_comb begin
        w_state   = r_state;
        w_bit     = r_bit;
        w_rep     = r_rep;
        w_gap     = r_gap;
        w_gap_cfg = r_gap_cfg;
        w_out     = 1'b0;
        w_vld     = 1'b0;
        w_done    = 1'b0;
        w_load    = 1'b0;
        w_reload  = 1'b0;
        w_shift   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    w_state   = SEND;
                    w_load    = 1'b1;
                    w_bit     = (w_len != '0) ? w_len - 1'b1 : '0;
                    w_rep     = w_reps;
                    w_gap     = '0;
                    w_gap_cfg = gap;
                    w_out     = w_load_msb;
                    w_vld     = (w_len != '0);
                end
            end
            SEND: begin
                if (abort) begin
                    w_state = IDLE;
                    w_bit   = '0;
                    w_rep   = '0;
                end else if (w_cur_len == '0 || (r_bit == '0 && r_rep == CNT_W'(1))) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                    w_rep   = '0;
                end else if (r_bit != '0) begin
                    w_bit   = r_bit - 1'b1;
                    w_shift = 1'b1;
                    w_out   = w_next_msb;
                    w_vld   = 1'b1;
                end else begin
                    w_rep = r_rep - 1'b1;
                    if (r_gap_cfg != '0) begin
                        w_state = GAP;
                        w_gap   = r_gap_cfg;
                    end else begin
                        w_reload = 1'b1;
                        w_bit    = w_cur_len - 1'b1;
                        w_out    = w_head_msb;
                        w_vld    = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    w_state = IDLE;
                    w_gap   = '0;
                    w_rep   = '0;
                end else if (r_gap == GAP_W'(1)) begin
                    w_state  = SEND;
                    w_gap    = '0;
                    w_reload = 1'b1;
                    w_bit    = w_cur_len - 1'b1;
                    w_out    = w_head_msb;
                    w_vld    = 1'b1;
                end else begin
                    w_gap = r_gap - 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign seq_out     = r_out;
    assign seq_vld     = r_vld;
    assign done        = r_done;
endmodule
